// File: rtl/alu_exec_seq_pkg.sv
// Shared ALU definitions: control codes (also decoded by the ALU controller),
// operand-B select encodings, execution FSM states and an operand-B helper.
package alu_exec_seq_pkg;

    localparam int DATA_W    = 32;
    localparam int MUL_ITERS = 32;
    localparam int CNT_W     = $clog2(MUL_ITERS);

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_MUL  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SHR  = 4'b1000,
        ALU_IDLE = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        SH_B     = 2'b00,  // operand B = b_i
        SH_SHAMT = 2'b01,  // operand B = shamt_i
        SH_ZEXT  = 2'b10   // operand B = zero-extended b_i[15:0]
    } shamt_ctrl_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exec_state_e;

    // Encoding 11 is unused and falls back to plain b_i.
    function automatic logic [DATA_W-1:0] operand_b(input logic [1:0]        sel,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic [4:0]        shamt);
        logic [DATA_W-1:0] r;
        case (sel)
            SH_SHAMT: r = {{(DATA_W-5){1'b0}}, shamt};
            SH_ZEXT:  r = {{(DATA_W-16){1'b0}}, b[15:0]};
            default:  r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_exec_seq_if.sv
// Request/response bundle of the ALU execution unit.
// master: issues operations (start_i, ALUCtrl_i, shamt_ctrl_i, src1_i, b_i,
//         shamt_i) and observes result_o, zero_o, valid_o, busy_o.
// slave:  the execution unit.
interface alu_exec_seq_if;
    import alu_exec_seq_pkg::*;

    logic              start_i;
    logic [3:0]        ALUCtrl_i;
    logic [1:0]        shamt_ctrl_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] b_i;
    logic [4:0]        shamt_i;
    logic [DATA_W-1:0] result_o;
    logic              zero_o;
    logic              valid_o;
    logic              busy_o;

    modport master (
        output start_i, ALUCtrl_i, shamt_ctrl_i, src1_i, b_i, shamt_i,
        input  result_o, zero_o, valid_o, busy_o
    );

    modport slave (
        input  start_i, ALUCtrl_i, shamt_ctrl_i, src1_i, b_i, shamt_i,
        output result_o, zero_o, valid_o, busy_o
    );

endinterface

// File: rtl/alu_exec_seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, 32 iterations.
// Ports: clk_i, rst_i (async, active-low), start_i (load operands),
//        a_i/b_i operands, done_o (high during the last iteration),
//        product_o (low 32 bits of the product, valid while done_o=1).
module alu_mul_seq
    import alu_exec_seq_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, acc_next;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q;

    // The final accumulate is exposed combinationally so the owner can
    // register the product on the same edge as the 32nd iteration.
    assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = run_q && (cnt_q == CNT_W'(MUL_ITERS - 1));
    assign product_o = acc_next;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i && !run_q) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;  // wraps back to 0 after the last iteration
            if (done_o) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec_seq.sv
// ALU execution unit: single-cycle logic/arith/compare/shift ops and a
// 32-cycle iterative multiply.
// Ports: clk_i, rst_i (async, active-low), bus (slave modport carrying the
//        request fields and result_o/zero_o/valid_o/busy_o).
module alu_exec_seq
    import alu_exec_seq_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    alu_exec_seq_if.slave bus
);

    exec_state_e       state_q, state_d;
    logic [DATA_W-1:0] opb, alu_res, mul_prod, result_q;
    logic [4:0]        shift_amt;
    logic              accept, mul_start, mul_done;
    logic              zero_q, valid_q;

    // start_i only matters while idle; busy requests are dropped.
    assign accept    = bus.start_i && (state_q == ST_IDLE);
    assign mul_start = accept && (bus.ALUCtrl_i == ALU_MUL);

    assign opb       = operand_b(bus.shamt_ctrl_i, bus.b_i, bus.shamt_i);
    assign shift_amt = (bus.shamt_ctrl_i == SH_SHAMT) ? bus.shamt_i : bus.src1_i[4:0];

    always_comb begin
        alu_res = '0;
        case (bus.ALUCtrl_i)
            ALU_AND: alu_res = bus.src1_i & opb;
            ALU_OR:  alu_res = bus.src1_i | opb;
            ALU_ADD: alu_res = bus.src1_i + opb;
            ALU_SUB: alu_res = bus.src1_i - opb;
            ALU_SLT: alu_res = (bus.shamt_ctrl_i == SH_ZEXT)
                             ? {{(DATA_W-1){1'b0}}, (bus.src1_i < opb)}
                             : {{(DATA_W-1){1'b0}}, ($signed(bus.src1_i) < $signed(opb))};
            ALU_SHR: alu_res = $signed(bus.b_i) >>> shift_amt;
            default: alu_res = '0;  // IDLE and unknown codes
        endcase
    end

    alu_mul_seq u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .a_i       (bus.src1_i),
        .b_i       (opb),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else if (accept && !mul_start) begin
            result_q <= alu_res;
            zero_q   <= (alu_res == '0);
            valid_q  <= 1'b1;
        end else if (mul_done) begin
            result_q <= mul_prod;
            zero_q   <= (mul_prod == '0);
            valid_q  <= 1'b1;
        end else begin
            valid_q  <= 1'b0;
        end
    end

    assign bus.result_o = result_q;
    assign bus.zero_o   = zero_q;
    assign bus.valid_o  = valid_q;
    assign bus.busy_o   = (state_q == ST_MUL);

endmodule
